// File: rtl/sized_memory.sv
// Byte-addressed Y86-64 unified memory.
// Sized valid/ready data port with read latency, plus a combinational fetch port.
module sized_memory #(
    parameter int    ADDR_W        = 16,
    parameter int    FETCH_BYTES   = 10,
    parameter int    RD_LATENCY    = 1,
    parameter string MEM_INIT_FILE = "program.mem"
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [1:0]               req_size,
    input  logic [63:0]              req_addr,
    input  logic [63:0]              req_wdata,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [63:0]              rsp_rdata,
    output logic                     rsp_err,
    input  logic [63:0]              pc,
    output logic [8*FETCH_BYTES-1:0] pc_out,
    output logic                     pc_err
);

    localparam int          DEPTH    = 2 ** ADDR_W;
    localparam logic [64:0] MAX_ADDR = (65'd1 << ADDR_W) - 65'd1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    logic [7:0]              r_mem [0:DEPTH-1];
    state_t                  r_state;
    logic [2:0]              r_cnt;
    logic                    r_ready;
    logic                    r_valid;
    logic [63:0]             r_rdata;
    logic                    r_err;

    logic                    w_accept;
    logic [3:0]              w_n;
    logic [64:0]             w_last;
    logic                    w_err;
    logic [ADDR_W-1:0]       w_idx;
    logic [63:0]             w_rdata;
    logic [64:0]             w_pa;
    logic                    w_pc_err;
    logic [8*FETCH_BYTES-1:0] w_pc_out;

    // RAM starts all-zero at start of time.
    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] = '0;
        end
    end

    assign w_accept = req_valid & r_ready;
    assign w_n      = 4'd1 << req_size;
    assign w_idx    = req_addr[ADDR_W-1:0];

    // 65-bit end address so a 64-bit wrap is caught as out of range.
    assign w_last   = {1'b0, req_addr} + {61'd0, w_n} - 65'd1;
    assign w_err    = (w_last > MAX_ADDR);

    // Little-endian, zero-extended read of the low N bytes.
    always_comb begin
        w_rdata = '0;
        for (int k = 0; k < 8; k++) begin
            if (4'(k) < w_n) begin
                w_rdata[8*k +: 8] = r_mem[w_idx + ADDR_W'(k)];
            end
        end
        if (w_err) begin
            w_rdata = '0;
        end
    end

    // Byte-lane write committed at the acceptance edge; RAM has no reset.
    always_ff @(posedge clock) begin
        if (w_accept && req_write && !w_err) begin
            for (int k = 0; k < 8; k++) begin
                if (4'(k) < w_n) begin
                    r_mem[w_idx + ADDR_W'(k)] <= req_wdata[8*k +: 8];
                end
            end
        end
    end

    // Request/response control FSM with registered handshake outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_ready <= 1'b0;
                        r_err   <= w_err;
                        r_rdata <= req_write ? 64'd0 : w_rdata;
                        if (req_write || RD_LATENCY == 1) begin
                            r_state <= S_RESP;
                            r_valid <= 1'b1;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= 3'(RD_LATENCY - 1);
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 3'd1) begin
                        r_state <= S_RESP;
                        r_valid <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_state <= S_IDLE;
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    // Fetch window: bytes past the top of memory read as zero, no wrap.
    always_comb begin
        w_pc_out = '0;
        w_pa     = '0;
        for (int k = 0; k < FETCH_BYTES; k++) begin
            w_pa = {1'b0, pc} + 65'(k);
            if (w_pa <= MAX_ADDR) begin
                w_pc_out[8*k +: 8] = r_mem[w_pa[ADDR_W-1:0]];
            end
        end
        if (w_pc_err) begin
            w_pc_out = '0;
        end
    end

    assign w_pc_err  = ({1'b0, pc} > MAX_ADDR);
    assign pc_err    = w_pc_err;
    assign pc_out    = w_pc_out;
    assign req_ready = r_ready;
    assign rsp_valid = r_valid;
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

endmodule
